pmem_fetch_ctrl: RTL and testbench
==================================

Name: pmem_fetch_ctrl

Overview:
- Sequencing and arbitration controller in front of the 16K x 16 program ROM (14-bit word address, asynchronous read data).
- Runs the CPU instruction-fetch stream: PC tracking, two-word instruction assembly (CALL/JMP/LDS/STS), flush on PC redirect.
- Shares the single ROM read port with LPM byte reads issued by the execute stage.
- Sits between the program ROM and the decode stage.

Parameters:
- ADDR_W, 14, program memory word-address width.
- DATA_W, 16, program word width; fixed at 16 for AVR encoding.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_W  ROM word address (combinational from state and inputs).
- mem_dout  in  DATA_W  ROM data; valid in the same cycle as mem_addr.
- pc_load  in  1  redirect/flush request (branch, call, ret, interrupt).
- pc_load_addr  in  ADDR_W  new PC value.
- stall  in  1  decode cannot accept; holds the output register.
- instr_valid  out  1  instr, instr_pc and instr_two_word are valid.
- instr  out  32  [31:16] first word; [15:0] second word, or 0 for a single-word instruction.
- instr_pc  out  ADDR_W  word address of the first word.
- instr_two_word  out  1  instr carries a 32-bit instruction.
- lpm_req  in  1  LPM read request; level, held until lpm_ack.
- lpm_addr  in  ADDR_W+1  LPM byte address (Z).
- lpm_ack  out  1  one-cycle pulse; lpm_data valid.
- lpm_data  out  8  LPM result byte.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on rst_n. While reset is asserted:
  - pc=0, state=FETCH1;
  - instr_valid=0, instr=0, instr_pc=0, instr_two_word=0;
  - lpm_ack=0, lpm_data=0;
  - hold register=0.
- States:
  - FETCH1: read the first word at pc.
  - FETCH2: read the second word at pc; the first word is held internally.
- Two-word detection on mem_dout in FETCH1:
  - CALL 1001010x_xxxx111x, JMP 1001010x_xxxx110x, LDS 1001000x_xxxx0000, STS 1001001x_xxxx0000.
  - Every other pattern is single-word.
- Output register occupancy:
  - Free when instr_valid=0, or instr_valid=1 && stall=0 (consumed this cycle).
  - While instr_valid=1 && stall=1, all outputs hold and the PC does not advance.
- Per-cycle priority (highest first):
  1. pc_load=1: pc<=pc_load_addr; state<=FETCH1; instr_valid<=0 (flush, including any held first word). No LPM grant this cycle. mem_addr=pc_load_addr; nothing is captured from it.
  2. LPM grant when lpm_req=1 && lpm_ack=0:
     - mem_addr=lpm_addr[ADDR_W:1].
     - Next edge: lpm_data<=lpm_addr[0] ? mem_dout[15:8] : mem_dout[7:0]; lpm_ack<=1.
     - Fetch does not advance. Back-to-back LPM throughput is 1 byte per 2 cycles.
  3. Fetch, mem_addr=pc:
     - FETCH1, single-word, output free: instr<={mem_dout,16'h0}, instr_pc<=pc, instr_two_word<=0, instr_valid<=1, pc<=pc+1.
     - FETCH1, two-word: hold<=mem_dout, pc<=pc+1, state<=FETCH2. The output does not need to be free for this step.
     - FETCH2, output free: instr<={hold,mem_dout}, instr_pc<=pc-1, instr_two_word<=1, instr_valid<=1, pc<=pc+1, state<=FETCH1.
     - Output not free: state and pc hold. If the output was consumed this cycle without a new load, instr_valid<=0.
- lpm_ack is high for exactly one cycle per grant.
- PC arithmetic is modulo 2^ADDR_W: pc 0x3FFF+1 gives 0x0000. A two-word instruction at 0x3FFF takes its second word from 0x0000; instr_pc reports 0x3FFF.
- Latency:
  - First instr_valid at the first rising edge after rst_n deasserts, if no LPM or pc_load is active.
  - Sustained throughput: 1 single-word instruction per cycle; a two-word instruction needs 2 cycles.
- Reset asserted mid-operation (FETCH2, LPM pending) aborts immediately to reset values. No lpm_ack is issued for an interrupted request.

Test Plan:
- Reset sequence: ROM[0]=0x0000, ROM[1]=0x940C, ROM[2]=0x0123, ROM[3]=0x2C01; release rst_n, stall=0.
  - Required: 0x00000000 with pc 0 at edge 1; 0x940C0123 with pc 1, two_word=1 at edge 3; 0x2C010000 with pc 3 at edge 4.
- Stall hold: set stall=1 while 0x2C010000 is valid, for 3 cycles.
  - Required: outputs and mem_addr stable for all 3 cycles; next instruction (pc 4) valid one edge after stall drops.
- LPM:
  - lpm_addr=0x0005 with ROM[2]=0x0123: one-cycle lpm_ack, lpm_data=0x01.
  - lpm_addr=0x0004: lpm_data=0x23.
  - Fetch PC is unchanged across each grant.
- Redirect during FETCH2:
  - pc_load=1, pc_load_addr=0x0040 in the cycle after the 0x940C fetch.
  - Required: no 0x940C instruction is emitted; next instr_pc=0x0040.
- Wrap:
  - ROM[0x3FFF]=0x940E, ROM[0]=0x1234; pc_load to 0x3FFF.
  - Required: instr=0x940E1234, instr_pc=0x3FFF, two_word=1; next instr_pc=0x0001.
- Simultaneous pc_load and lpm_req: pc applied, no lpm_ack that cycle; ack follows on the next edge.

Source files
------------

// File: rtl/pmem_fetch_ctrl.sv
// Program-memory fetch controller: sequences instruction fetch from the
// 16K x 16 program ROM, assembles two-word AVR instructions, flushes on PC
// redirect and shares the ROM read port with LPM byte reads.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_addr         ROM word address (combinational)
//   mem_dout         ROM read data (valid in the same cycle as mem_addr)
//   pc_load          redirect/flush request, pc_load_addr = new PC
//   stall            decode cannot accept; output register holds
//   instr_valid      instr / instr_pc / instr_two_word valid
//   instr            {first word, second word or 0}
//   instr_pc         word address of the first word
//   instr_two_word   instr carries a 32-bit instruction
//   lpm_req          LPM request level, lpm_addr = byte address (Z)
//   lpm_ack          one-cycle pulse, lpm_data valid
//   lpm_data         LPM result byte
module pmem_fetch_ctrl #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_dout,
    input  logic                  pc_load,
    input  logic [ADDR_W-1:0]     pc_load_addr,
    input  logic                  stall,
    output logic                  instr_valid,
    output logic [2*DATA_W-1:0]   instr,
    output logic [ADDR_W-1:0]     instr_pc,
    output logic                  instr_two_word,
    input  logic                  lpm_req,
    input  logic [ADDR_W:0]       lpm_addr,
    output logic                  lpm_ack,
    output logic [7:0]            lpm_data
);

    localparam int unsigned INSTR_W = 2 * DATA_W;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic {
        FETCH1 = 1'b0,
        FETCH2 = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]    hold_q, hold_d;
    logic                 valid_d;
    logic [INSTR_W-1:0]   instr_d;
    logic [ADDR_W-1:0]    instr_pc_d;
    logic                 two_word_d;
    logic                 ack_d;
    logic [BYTE_W-1:0]    lpm_data_d;

    logic                 out_free;
    logic                 lpm_grant;
    logic                 two_word;

    // Output register can take a new instruction: empty or consumed this cycle.
    assign out_free  = !instr_valid || !stall;
    // LPM wins over fetch, except during a redirect; ack cycle blocks re-grant.
    assign lpm_grant = lpm_req && !lpm_ack && !pc_load;

    // CALL/JMP: 1001010x_xxxx11xx, LDS/STS: 100100xx_xxxx0000.
    assign two_word = ((mem_dout[DATA_W-1:9] == 7'b1001010) && (mem_dout[3:2] == 2'b11)) ||
                      ((mem_dout[DATA_W-1:10] == 6'b100100) && (mem_dout[3:0] == 4'b0000));

    // Single ROM port address mux.
    always_comb begin
        mem_addr = pc_q;
        if (pc_load) begin
            mem_addr = pc_load_addr;
        end else if (lpm_grant) begin
            mem_addr = lpm_addr[ADDR_W:1];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        valid_d    = instr_valid;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        two_word_d = instr_two_word;
        ack_d      = 1'b0;
        lpm_data_d = lpm_data;

        if (pc_load) begin
            pc_d    = pc_load_addr;
            state_d = FETCH1;
            valid_d = 1'b0;
        end else begin
            // A consumed entry empties unless refilled below.
            if (out_free) begin
                valid_d = 1'b0;
            end
            if (lpm_grant) begin
                ack_d      = 1'b1;
                lpm_data_d = lpm_addr[0] ? mem_dout[DATA_W-1 -: BYTE_W] : mem_dout[BYTE_W-1:0];
            end else if (state_q == FETCH1) begin
                if (two_word) begin
                    // First word only goes to the hold register, so no need for a free output.
                    hold_d  = mem_dout;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = FETCH2;
                end else if (out_free) begin
                    instr_d    = {mem_dout, DATA_W'(0)};
                    instr_pc_d = pc_q;
                    two_word_d = 1'b0;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                end
            end else if (out_free) begin
                instr_d    = {hold_q, mem_dout};
                instr_pc_d = pc_q - ADDR_W'(1);
                two_word_d = 1'b1;
                valid_d    = 1'b1;
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = FETCH1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FETCH1;
            pc_q           <= '0;
            hold_q         <= '0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
            instr_two_word <= 1'b0;
            lpm_ack        <= 1'b0;
            lpm_data       <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_q         <= hold_d;
            instr_valid    <= valid_d;
            instr          <= instr_d;
            instr_pc       <= instr_pc_d;
            instr_two_word <= two_word_d;
            lpm_ack        <= ack_d;
            lpm_data       <= lpm_data_d;
        end
    end

endmodule

// File: tb/tb_pmem_fetch_ctrl.sv
// Self-checking bench for pmem_fetch_ctrl: directed scenarios followed by a
// randomized run scored against an instruction-stream reference model.
module tb_pmem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] mem_addr;
    logic [15:0] mem_dout;
    logic        pc_load;
    logic [13:0] pc_load_addr;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [13:0] instr_pc;
    logic        instr_two_word;
    logic        lpm_req;
    logic [14:0] lpm_addr;
    logic        lpm_ack;
    logic [7:0]  lpm_data;

    logic [15:0] rom [0:16383];

    int vectors = 0;
    int errors  = 0;

    assign mem_dout = rom[mem_addr];

    always #5 clk = ~clk;

    pmem_fetch_ctrl #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_two_word(instr_two_word), .lpm_req(lpm_req), .lpm_addr(lpm_addr),
        .lpm_ack(lpm_ack), .lpm_data(lpm_data)
    );

    // Opcode classes that carry a second word.
    function automatic bit is_two(input logic [15:0] w);
        return (w ==? 16'b1001010?_????111?) || (w ==? 16'b1001010?_????110?) ||
               (w ==? 16'b1001000?_????0000) || (w ==? 16'b1001001?_????0000);
    endfunction

    function automatic logic [7:0] lpm_byte(input logic [14:0] a);
        logic [15:0] w;
        w = rom[a[14:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 16384; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            case ($urandom % 8)
                0: rom[i] = 16'h940C | (r & 16'h01F1);
                1: rom[i] = 16'h940E | (r & 16'h01F1);
                2: rom[i] = 16'h9000 | (r & 16'h01F0);
                3: rom[i] = 16'h9200 | (r & 16'h01F0);
                default: rom[i] = r;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_load = 1'b0; pc_load_addr = '0; stall = 1'b0;
        lpm_req = 1'b0; lpm_addr = '0;
        rom[0] = 16'h0000; rom[1] = 16'h940C; rom[2] = 16'h0123; rom[3] = 16'h2C01;
        rom[4] = 16'h1111;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({instr_valid, instr, instr_pc, instr_two_word, lpm_ack, lpm_data} !== 57'd0)
            begin errors++; $display("FAIL reset_values: got valid=%b instr=%h pc=%h tw=%b ack=%b data=%h, expected all zero",
                instr_valid, instr, instr_pc, instr_two_word, lpm_ack, lpm_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({instr_valid, instr, instr_pc, instr_two_word} !== {1'b1, 32'h0, 14'h0, 1'b0})
            begin errors++; $display("FAIL reset_edge1: got valid=%b instr=%h pc=%h tw=%b, expected 1 00000000 0000 0",
                instr_valid, instr, instr_pc, instr_two_word); end
        tick(); tick();
        vectors++;
        if ({instr_valid, instr, instr_pc, instr_two_word} !== {1'b1, 32'h940C0123, 14'h1, 1'b1})
            begin errors++; $display("FAIL reset_edge3: got valid=%b instr=%h pc=%h tw=%b, expected 1 940c0123 0001 1",
                instr_valid, instr, instr_pc, instr_two_word); end
        tick();
        vectors++;
        if ({instr_valid, instr, instr_pc, instr_two_word} !== {1'b1, 32'h2C010000, 14'h3, 1'b0})
            begin errors++; $display("FAIL reset_edge4: got valid=%b instr=%h pc=%h tw=%b, expected 1 2c010000 0003 0",
                instr_valid, instr, instr_pc, instr_two_word); end
    endtask

    task automatic test_stall();
        logic [13:0] addr0;
        stall = 1'b1;
        #1 addr0 = mem_addr;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({instr_valid, instr, instr_pc, mem_addr} !== {1'b1, 32'h2C010000, 14'h3, addr0})
                begin errors++; $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h addr=%h, expected 1 2c010000 0003 %h",
                    k, instr_valid, instr, instr_pc, mem_addr, addr0); end
        end
        stall = 1'b0;
        tick();
        vectors++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h11110000, 14'h4})
            begin errors++; $display("FAIL stall_release: got valid=%b instr=%h pc=%h, expected 1 11110000 0004",
                instr_valid, instr, instr_pc); end
    endtask

    task automatic test_lpm();
        logic [14:0] addrs [2];
        logic [7:0]  exp   [2];
        logic [13:0] pc_before;
        addrs[0] = 15'h0005; exp[0] = 8'h01;
        addrs[1] = 15'h0004; exp[1] = 8'h23;
        for (int k = 0; k < 2; k++) begin
            pc_before = mem_addr;
            lpm_req = 1'b1; lpm_addr = addrs[k];
            #1;
            vectors++;
            if (mem_addr !== 14'h2)
                begin errors++; $display("FAIL lpm_addr[%0d]: got %h, expected 0002", k, mem_addr); end
            tick();
            vectors++;
            if ({lpm_ack, lpm_data} !== {1'b1, exp[k]})
                begin errors++; $display("FAIL lpm_data[%0d]: got ack=%b data=%h, expected 1 %h", k, lpm_ack, lpm_data, exp[k]); end
            lpm_req = 1'b0;
            #1;
            vectors++;
            if (mem_addr !== pc_before)
                begin errors++; $display("FAIL lpm_pc_hold[%0d]: got %h, expected %h", k, mem_addr, pc_before); end
            tick();
            vectors++;
            if (lpm_ack !== 1'b0)
                begin errors++; $display("FAIL lpm_pulse[%0d]: got ack=%b, expected 0", k, lpm_ack); end
        end
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] ei, input logic [13:0] ep,
                              input logic et, input int budget);
        bit found = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (instr_valid === 1'b1) begin found = 1; break; end
        end
        vectors++;
        if (!found) begin
            errors++; $display("FAIL %s: no instr_valid within %0d cycles, expected pc %h", nm, budget, ep);
        end else if ({instr, instr_pc, instr_two_word} !== {ei, ep, et}) begin
            errors++; $display("FAIL %s: got instr=%h pc=%h tw=%b, expected %h %h %b",
                nm, instr, instr_pc, instr_two_word, ei, ep, et);
        end
    endtask

    task automatic test_redirect();
        rom[14'h20] = 16'h940C; rom[14'h21] = 16'hABCD; rom[14'h40] = 16'h0001;
        pc_load = 1'b1; pc_load_addr = 14'h20;
        tick();
        pc_load = 1'b0;
        tick();
        vectors++;
        if (instr_valid !== 1'b0)
            begin errors++; $display("FAIL redirect_fetch2: got valid=%b, expected 0", instr_valid); end
        pc_load = 1'b1; pc_load_addr = 14'h40;
        tick();
        pc_load = 1'b0;
        wait_valid("redirect_target", 32'h00010000, 14'h40, 1'b0, 3);
    endtask

    task automatic test_wrap();
        rom[14'h3FFF] = 16'h940E; rom[0] = 16'h1234;
        pc_load = 1'b1; pc_load_addr = 14'h3FFF;
        tick();
        pc_load = 1'b0;
        wait_valid("wrap_two_word", 32'h940E1234, 14'h3FFF, 1'b1, 4);
        wait_valid("wrap_next", 32'h940C0123, 14'h0001, 1'b1, 3);
    endtask

    task automatic test_simultaneous();
        pc_load = 1'b1; pc_load_addr = 14'h100;
        lpm_req = 1'b1; lpm_addr = 15'h0005;
        tick();
        pc_load = 1'b0;
        vectors++;
        if (lpm_ack !== 1'b0)
            begin errors++; $display("FAIL simul_no_ack: got ack=%b, expected 0", lpm_ack); end
        tick();
        vectors++;
        if ({lpm_ack, lpm_data} !== {1'b1, 8'h01})
            begin errors++; $display("FAIL simul_ack: got ack=%b data=%h, expected 1 01", lpm_ack, lpm_data); end
        lpm_req = 1'b0;
        #1;
        vectors++;
        if (mem_addr !== 14'h100)
            begin errors++; $display("FAIL simul_pc: got %h, expected 0100", mem_addr); end
    endtask

    task automatic test_reset_abort();
        pc_load = 1'b1; pc_load_addr = 14'h20;
        tick();
        pc_load = 1'b0;
        tick();
        lpm_req = 1'b1; lpm_addr = 15'h0004;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({instr_valid, instr, instr_pc, instr_two_word, lpm_ack, lpm_data} !== 57'd0)
            begin errors++; $display("FAIL abort_values: got valid=%b instr=%h pc=%h tw=%b ack=%b data=%h, expected all zero",
                instr_valid, instr, instr_pc, instr_two_word, lpm_ack, lpm_data); end
        lpm_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (lpm_ack !== 1'b0)
                begin errors++; $display("FAIL abort_no_ack[%0d]: got ack=%b, expected 0", k, lpm_ack); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h12340000, 14'h0})
            begin errors++; $display("FAIL abort_restart: got valid=%b instr=%h pc=%h, expected 1 12340000 0000",
                instr_valid, instr, instr_pc); end
    endtask

    // Random traffic vs. an in-order instruction-stream model.
    task automatic test_random(input int n);
        logic [13:0] model_pc = '0;
        bit          synced = 0, prev_grant = 0, prev_hold = 0;
        logic [31:0] s_instr = '0;
        logic [13:0] s_pc = '0;
        logic        s_two = 1'b0;
        int          idle = 0;
        fill_rom();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vectors++;
            if (lpm_ack !== prev_grant)
                begin errors++; $display("FAIL rnd_ack[%0d]: got %b, expected %b", i, lpm_ack, prev_grant); end
            if (prev_grant && lpm_ack === 1'b1) begin
                vectors++;
                if (lpm_data !== lpm_byte(lpm_addr))
                    begin errors++; $display("FAIL rnd_lpm[%0d]: addr=%h got %h, expected %h", i, lpm_addr, lpm_data, lpm_byte(lpm_addr)); end
            end
            if (prev_hold) begin
                vectors++;
                if ({instr_valid, instr, instr_pc, instr_two_word} !== {1'b1, s_instr, s_pc, s_two})
                    begin errors++; $display("FAIL rnd_hold[%0d]: got %b %h %h %b, expected 1 %h %h %b",
                        i, instr_valid, instr, instr_pc, instr_two_word, s_instr, s_pc, s_two); end
            end

            if (lpm_ack) lpm_req = 1'b0;
            else if (!lpm_req && ($urandom % 6) == 0) begin lpm_req = 1'b1; lpm_addr = 15'($urandom); end
            stall   = ($urandom % 4) == 0;
            pc_load = (i == 0) || (($urandom % 24) == 0);
            if (pc_load) pc_load_addr = ($urandom % 2) ? 14'($urandom) : 14'(14'h3FFC + 14'($urandom % 4));

            if (instr_valid && !stall && synced) begin
                logic [15:0] w1;
                logic [31:0] ei;
                bit tw;
                w1 = rom[model_pc];
                tw = is_two(w1);
                ei = tw ? {w1, rom[14'(model_pc + 14'd1)]} : {w1, 16'h0};
                vectors++;
                if ({instr, instr_pc, instr_two_word} !== {ei, model_pc, tw})
                    begin errors++; $display("FAIL rnd_instr[%0d]: got %h pc=%h tw=%b, expected %h pc=%h tw=%b",
                        i, instr, instr_pc, instr_two_word, ei, model_pc, tw); end
                model_pc = model_pc + (tw ? 14'd2 : 14'd1);
            end
            if (pc_load) begin model_pc = pc_load_addr; synced = 1; end

            prev_grant = lpm_req && !lpm_ack && !pc_load;
            prev_hold  = instr_valid && stall && !pc_load;
            s_instr = instr; s_pc = instr_pc; s_two = instr_two_word;

            if (!instr_valid && !pc_load && !prev_grant) idle++;
            else idle = 0;
            vectors++;
            if (idle > 2) begin
                errors++; $display("FAIL rnd_progress[%0d]: %0d idle fetch cycles, expected at most 2", i, idle);
                idle = 0;
            end
        end
        @(negedge clk);
        lpm_req = 1'b0; pc_load = 1'b0; stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 16'h0000;
        test_reset();
        test_stall();
        test_lpm();
        test_redirect();
        test_wrap();
        test_simultaneous();
        test_reset_abort();
        test_random(4000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
